// File: rtl/serial_pkg.sv
// Shared definitions for the serial link blocks.
// Holds the FSM state type and the default word width.
package serial_pkg;

   localparam int SER_WIDTH = 4;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry hold buffer for the piso transmitter.
// Captures a word on load, releases it on take.
module piso_hold_buf #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             take,
   output logic [WIDTH-1:0] dout,
   output logic             full
);

   // load only happens when empty, take only when full
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout <= '0;
         full <= 1'b0;
      end else if (load) begin
         dout <= din;
         full <= 1'b1;
      end else if (take) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a one-word hold buffer.
// Streams words back to back; all outputs except pi_ready are registered.
module piso_tx
   import serial_pkg::*;
#(
   parameter int WIDTH     = SER_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pi,
   input  logic             pi_valid,
   output logic             pi_ready,
   output logic             so,
   output logic             so_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_n;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_n;
   logic [WIDTH-1:0] hold_dout;
   logic             hold_full;
   logic             hold_full_n;
   logic             last;
   logic             xfer;
   logic             direct;
   logic             take;
   logic             hold_load;
   logic             bit_n;

   assign pi_ready    = ~hold_full;
   assign last        = (state == SHIFT) && (cnt == LAST);
   assign xfer        = pi_valid & ~hold_full;
   assign direct      = xfer & ((state == IDLE) | last);
   assign take        = last & hold_full;
   assign hold_load   = xfer & ~direct;
   assign hold_full_n = hold_load | (hold_full & ~take);
   assign bit_n       = MSB_FIRST ? sr_n[WIDTH-1] : sr_n[0];

   piso_hold_buf #(
      .WIDTH(WIDTH)
   ) u_hold (
      .clk  (clk),
      .reset(reset),
      .load (hold_load),
      .din  (pi),
      .take (take),
      .dout (hold_dout),
      .full (hold_full)
   );

   // next shifter state: reload from hold, reload from pi, or shift
   always_comb begin
      state_n = state;
      sr_n    = sr;
      cnt_n   = cnt;
      if (take) begin
         state_n = SHIFT;
         sr_n    = hold_dout;
         cnt_n   = '0;
      end else if (direct) begin
         state_n = SHIFT;
         sr_n    = pi;
         cnt_n   = '0;
      end else if (state == SHIFT) begin
         if (last) begin
            state_n = IDLE;
            sr_n    = '0;
            cnt_n   = '0;
         end else begin
            sr_n  = MSB_FIRST ? (sr << 1) : (sr >> 1);
            cnt_n = cnt + 1'b1;
         end
      end
   end

   // shifter state and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         sr        <= '0;
         cnt       <= '0;
         so        <= 1'b0;
         so_valid  <= 1'b0;
         word_done <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         sr        <= sr_n;
         cnt       <= cnt_n;
         so        <= (state_n == SHIFT) & bit_n;
         so_valid  <= (state_n == SHIFT);
         word_done <= (state_n == SHIFT) && (cnt_n == LAST);
         busy      <= (state_n == SHIFT) | hold_full_n;
      end
   end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx (MSB-first and LSB-first instances)
// with a small sipo model on the loopback path.
module tb_piso_tx;

   typedef struct {
      logic b;
      logic l;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] pi;
   logic       pi_valid;
   logic       pi_ready;
   logic       so;
   logic       so_valid;
   logic       word_done;
   logic       busy;

   logic [3:0] pi_l;
   logic       pv_l;
   logic       pr_l;
   logic       so_l;
   logic       sv_l;
   logic       wd_l;
   logic       busy_l;

   logic [3:0] sipo_sr;
   logic [3:0] po;
   logic       done_d;

   exp_t q[$];
   exp_t ql[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   vcnt  = 0;
   int   dcnt  = 0;
   int   gaps  = 0;
   int   wt;

   always #5 clk = ~clk;

   piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
      .clk      (clk),
      .reset    (reset),
      .pi       (pi),
      .pi_valid (pi_valid),
      .pi_ready (pi_ready),
      .so       (so),
      .so_valid (so_valid),
      .word_done(word_done),
      .busy     (busy)
   );

   piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
      .clk      (clk),
      .reset    (reset),
      .pi       (pi_l),
      .pi_valid (pv_l),
      .pi_ready (pr_l),
      .so       (so_l),
      .so_valid (sv_l),
      .word_done(wd_l),
      .busy     (busy_l)
   );

   // downstream sipo model: shift, then latch po the edge after done
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         sipo_sr <= '0;
         po      <= '0;
         done_d  <= 1'b0;
      end else begin
         if (so_valid) sipo_sr <= {sipo_sr[2:0], so};
         done_d <= word_done;
         if (done_d) po <= sipo_sr;
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // scoreboard for the MSB-first instance
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (so_valid) begin
            vcnt++;
            if (word_done) dcnt++;
            if (q.size() == 0) chk("extra_bit", 1, 0);
            else begin
               e = q.pop_front();
               chk("so", so, e.b);
               chk("word_done", word_done, e.l);
            end
         end else begin
            if (q.size() != 0) gaps++;
            if (so !== 1'b0) chk("so_idle", so, 0);
            if (word_done !== 1'b0) chk("done_idle", word_done, 0);
         end
      end
   end

   // scoreboard for the LSB-first instance
   always @(negedge clk) begin
      exp_t e;
      if (!reset && sv_l) begin
         if (ql.size() == 0) chk("extra_bit_l", 1, 0);
         else begin
            e = ql.pop_front();
            chk("so_l", so_l, e.b);
            chk("word_done_l", wd_l, e.l);
         end
      end
   end

   task automatic clr();
      vcnt = 0;
      dcnt = 0;
      gaps = 0;
   endtask

   task automatic send(input logic [3:0] w, output int t);
      t = 0;
      pi = w;
      pi_valid = 1'b1;
      while (!pi_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      for (int i = 3; i >= 0; i--)
         q.push_back('{b: w[i], l: (i == 0)});
   endtask

   task automatic drain();
      int t = 0;
      while ((q.size() > 0 || ql.size() > 0) && t < 200) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk("drain", q.size() + ql.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      pi = '0;
      pi_valid = 1'b0;
      pi_l = '0;
      pv_l = 1'b0;
      #1 reset = 1'b1;
      #2;
      chk("rst_so", so, 0);
      chk("rst_so_valid", so_valid, 0);
      chk("rst_word_done", word_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pi_ready", pi_ready, 1);
      chk("rst_pr_l", pr_l, 1);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // single word, MSB first
      clr();
      send(4'b1011, wt);
      pi_valid = 1'b0;
      pi = 4'hF;
      drain();
      @(negedge clk);
      chk("single_nvalid", vcnt, 4);
      chk("single_ndone", dcnt, 1);
      chk("single_gaps", gaps, 0);
      chk("single_busy", busy, 0);

      // two words back to back
      clr();
      send(4'hA, wt);
      send(4'h5, wt);
      chk("hold_ready", pi_ready, 0);
      chk("hold_busy", busy, 1);
      pi_valid = 1'b0;
      drain();
      @(negedge clk);
      chk("pair_nvalid", vcnt, 8);
      chk("pair_ndone", dcnt, 2);
      chk("pair_gaps", gaps, 0);

      // third word while hold buffer full
      clr();
      send(4'hA, wt);
      send(4'h5, wt);
      send(4'h3, wt);
      chk("ready_wait", wt, 4);
      pi_valid = 1'b0;
      drain();
      @(negedge clk);
      chk("tri_nvalid", vcnt, 12);
      chk("tri_ndone", dcnt, 3);
      chk("tri_gaps", gaps, 0);
      chk("tri_busy", busy, 0);

      // LSB-first instance
      pi_l = 4'b0001;
      pv_l = 1'b1;
      chk("lsb_ready", pr_l, 1);
      @(posedge clk);
      #1;
      pv_l = 1'b0;
      for (int i = 0; i < 4; i++)
         ql.push_back('{b: pi_l[i], l: (i == 3)});
      drain();

      // reset mid-stream
      clr();
      send(4'hA, wt);
      send(4'h5, wt);
      pi_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_valid", so_valid, 1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_so", so, 0);
      chk("mid_rst_so_valid", so_valid, 0);
      chk("mid_rst_pi_ready", pi_ready, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_word_done", word_done, 0);
      q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      clr();
      repeat (10) @(negedge clk);
      #1;
      chk("residual_bits", vcnt, 0);
      chk("residual_busy", busy, 0);

      // transfer on first edge after reset release
      @(posedge clk);
      #1 reset = 1'b1;
      #2 reset = 1'b0;
      clr();
      send(4'b1011, wt);
      chk("rst_first_wait", wt, 0);
      pi_valid = 1'b0;
      drain();
      chk("restart_nvalid", vcnt, 4);
      chk("restart_gaps", gaps, 0);

      // loopback into sipo model
      send(4'hC, wt);
      pi_valid = 1'b0;
      wt = 0;
      while (!word_done && wt < 20) begin
         @(negedge clk);
         wt++;
      end
      chk("loop_done_seen", word_done, 1);
      @(posedge clk);
      #1 chk("sipo_po_early", po, 4'hB);
      @(posedge clk);
      #1 chk("sipo_po", po, 4'hC);
      drain();

      chk("q_left", q.size(), 0);
      chk("ql_left", ql.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, setting the parallel word width in bits.
REQ-002 The module SHALL have parameter MSB_FIRST, default 1; 1 serializes bit WIDTH-1 first, 0 serializes bit 0 first.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port pi, input, WIDTH bits: the parallel word to send.
REQ-006 The module SHALL have port pi_valid, input, 1 bit: pi holds a word to send.
REQ-007 The module SHALL have port pi_ready, output, 1 bit: the block can accept a word this cycle.
REQ-008 The module SHALL have port so, output, 1 bit: serial data out, feeding the si input of the downstream sipo.
REQ-009 The module SHALL have port so_valid, output, 1 bit: so carries a payload bit this cycle.
REQ-010 The module SHALL have port word_done, output, 1 bit: one-cycle pulse while the last bit of a word is on so.
REQ-011 The module SHALL have port busy, output, 1 bit: the shifter or the hold buffer is occupied.

Function
REQ-012 A transfer SHALL occur on a rising edge where pi_valid and pi_ready are both 1; pi_ready SHALL equal NOT hold_full.
REQ-013 Storage SHALL be one shift register, one one-entry hold buffer (data plus hold_full), and a bit counter of width clog2(WIDTH).
REQ-014 FSM states SHALL be IDLE and SHIFT; IDLE->SHIFT on a transfer; SHIFT->IDLE on the last bit when the hold buffer is empty and there is no transfer.
REQ-015 A transfer SHALL load the shift register directly when the FSM is in IDLE, or in SHIFT on the last bit; otherwise the word SHALL go to the hold buffer.
REQ-016 On the last bit with hold_full=1, the hold buffer SHALL move into the shift register and hold_full SHALL clear at the same edge.
REQ-017 Latency: a word transferred at edge N SHALL put its first bit on so in the cycle after edge N when loaded directly.
REQ-018 Each word SHALL occupy exactly WIDTH consecutive cycles with so_valid=1, in the order set by MSB_FIRST.
REQ-019 Back-to-back words SHALL stream with no idle cycle between them.
REQ-020 When so_valid=0, so SHALL be 0.
REQ-021 word_done SHALL be 1 exactly when the counter equals WIDTH-1 in state SHIFT.
REQ-022 busy SHALL be (state==SHIFT) OR hold_full.
REQ-023 Changes on pi while no transfer occurs SHALL have no effect.
REQ-024 A word, once accepted, SHALL never be dropped or repeated; no transfer SHALL occur while hold_full=1.

Reset
REQ-025 While reset=1, the block SHALL hold so=0, so_valid=0, word_done=0, busy=0, pi_ready=1, state=IDLE, counter=0, hold_full=0.
REQ-026 Reset asserted mid-word SHALL abort the current word and discard the hold buffer immediately, without waiting for a clock edge.
REQ-027 The first transfer after reset SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-028 Package serial_pkg SHALL hold the FSM state enum (IDLE, SHIFT) and constant SER_WIDTH=4, shared with sipo.
REQ-029 The hold buffer SHALL be a sub-module named piso_hold_buf with ports clk, reset, load, din, take, dout and full.
REQ-030 Outputs SHALL be driven directly from registers; the only exception is pi_ready, which is NOT hold_full.

Verification
REQ-031 The bench SHALL check: reset pulse mid-stream -> so=0, so_valid=0, pi_ready=1 immediately, with no residual bits afterwards.
REQ-032 The bench SHALL check: single word pi=4'b1011, MSB_FIRST=1 -> so = 1,0,1,1 over 4 cycles, so_valid=1 for those cycles, word_done=1 in the 4th.
REQ-033 The bench SHALL check: words 4'hA then 4'h5 with pi_valid held -> 8 contiguous bits 1010_0101, so_valid never drops, word_done pulses twice.
REQ-034 The bench SHALL check: a third word 4'h3 presented while the hold buffer is full -> pi_ready=0 until the 4'hA word ends, then 4'h3 is sent after 4'h5.
REQ-035 The bench SHALL check: MSB_FIRST=0 with pi=4'b0001 -> so = 1,0,0,0.
REQ-036 The bench SHALL check: loopback into sipo with pi=4'hC -> sipo po = 4'hC on the second rising edge after word_done was sampled high.
